// File: rtl/apb_periph_node_to_pkg.sv
// Shared types for the registered APB peripheral node: FSM states, error causes, default error data.
// Pure declarations; no logic, no latency.
package apb_periph_node_to_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_cause_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADACCE5;

endpackage

// File: rtl/apb_periph_node_to_if.sv
// APB4 signal bundle; NB is the select width (1 upstream, NB_SLAVES downstream, responses flattened per port).
// Wires only; no latency, flow control is the APB pready handshake.
interface apb_periph_node_to_if #(
  parameter int NB = 1,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic [DW/8-1:0]  pstrb;
  logic             pwrite;
  logic [NB-1:0]    psel;
  logic             penable;
  logic [NB*DW-1:0] prdata;
  logic [NB-1:0]    pready;
  logic [NB-1:0]    pslverr;

  modport master (
    output paddr, pwdata, pstrb, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pstrb, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_periph_node_to_addr_dec.sv
// Combinational address range decoder; lowest matching index wins, start>end ranges never match.
// Zero latency, no flow control.
module apb_periph_node_to_addr_dec #(
  parameter int NB_SLAVES  = 12,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = 4
) (
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] end_addr_i,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  output logic                            match_o,
  output logic [IDX_W-1:0]                idx_o
);

  // Scanning downwards lets the lowest matching index overwrite the others.
  always_comb begin
    match_o = 1'b0;
    idx_o   = '0;
    for (int i = NB_SLAVES - 1; i >= 0; i--) begin
      if ((start_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] <= addr_i) &&
          (addr_i <= end_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        match_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb_periph_node_to.sv
// Registered APB node: one upstream port fanned out to NB_SLAVES by address range, with decode-error and timeout responses.
// Latency: zero-wait slave answers upstream 3 cycles after setup (decode error after 1); upstream is held off by pready_o.
module apb_periph_node_to
  import apb_periph_node_to_pkg::*;
#(
  parameter int          NB_SLAVES      = 12,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] start_addr_i,
  input  logic [NB_SLAVES*ADDR_WIDTH-1:0] end_addr_i,
  apb_periph_node_to_if.slave             up,
  apb_periph_node_to_if.master            dn,
  output logic                            decerr_o,
  output logic                            timeout_o,
  output logic [ADDR_WIDTH-1:0]           err_addr_o
);

  localparam int IDX_W  = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d, prdata_q, prdata_d;
  logic [STRB_W-1:0]      strb_q, strb_d;
  logic                   write_q, write_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NB_SLAVES-1:0]   psel_q, psel_d;
  logic                   penable_q, penable_d, pready_q, pready_d, pslverr_q, pslverr_d;
  logic                   decerr_q, decerr_d, timeout_q, timeout_d;

  logic                   dec_match;
  logic [IDX_W-1:0]       dec_idx;
  logic                   resp_go;
  err_cause_e             cause;

  apb_periph_node_to_addr_dec #(
    .NB_SLAVES (NB_SLAVES),
    .ADDR_WIDTH(ADDR_WIDTH),
    .IDX_W     (IDX_W)
  ) u_dec (
    .start_addr_i(start_addr_i),
    .end_addr_i  (end_addr_i),
    .addr_i      (up.paddr),
    .match_o     (dec_match),
    .idx_o       (dec_idx)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    write_d    = write_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_addr_d = err_addr_q;
    psel_d     = '0;
    penable_d  = 1'b0;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    decerr_d   = 1'b0;
    timeout_d  = 1'b0;
    resp_go    = 1'b0;
    cause      = ERR_NONE;

    case (state_q)
      IDLE: begin
        if (up.psel[0] && !up.penable) begin
          addr_d  = up.paddr;
          wdata_d = up.pwdata;
          strb_d  = up.pstrb;
          write_d = up.pwrite;
          if (dec_match) begin
            state_d = SETUP;
            idx_d   = dec_idx;
            psel_d  = NB_SLAVES'(1) << dec_idx;
          end else begin
            resp_go    = 1'b1;
            cause      = ERR_DECODE;
            err_addr_d = up.paddr;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        cnt_d     = '0;
        psel_d    = psel_q;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (dn.pready[idx_q]) begin
          resp_go = 1'b1;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          resp_go    = 1'b1;
          cause      = ERR_TIMEOUT;
          err_addr_d = addr_q;
        end else begin
          psel_d    = psel_q;
          penable_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Response is registered on entry to RESP so pready_o/prdata_o come straight from flops.
    if (resp_go) begin
      state_d   = RESP;
      pready_d  = 1'b1;
      decerr_d  = (cause == ERR_DECODE);
      timeout_d = (cause == ERR_TIMEOUT);
      if (cause == ERR_NONE) begin
        prdata_d  = dn.prdata[idx_q*DATA_WIDTH +: DATA_WIDTH];
        pslverr_d = dn.pslverr[idx_q];
      end else begin
        prdata_d  = DATA_WIDTH'(ERR_DATA);
        pslverr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      write_q    <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      err_addr_q <= '0;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      decerr_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      err_addr_q <= err_addr_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      decerr_q   <= decerr_d;
      timeout_q  <= timeout_d;
    end
  end

  assign dn.paddr   = addr_q;
  assign dn.pwdata  = wdata_q;
  assign dn.pstrb   = strb_q;
  assign dn.pwrite  = write_q;
  assign dn.psel    = psel_q;
  assign dn.penable = penable_q;

  assign up.prdata  = prdata_q;
  assign up.pready  = pready_q;
  assign up.pslverr = pslverr_q;

  assign decerr_o   = decerr_q;
  assign timeout_o  = timeout_q;
  assign err_addr_o = err_addr_q;

endmodule
